// File: rtl/uart_cmd_router.sv
// rtl/uart_cmd_router.sv - UART command decoder, button debouncer and per-mode tick router
// Purpose: decodes one- and two-byte commands from a first-word-fall-through RX FIFO
//   ("m" next mode, "t" event, "M<d>" set mode, "b<d>" pulse button), debounces raw
//   buttons and routes button ticks onto the slice of the currently selected mode.
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   sw                 mode select switches (any edge loads the mode)
//   btn                raw push buttons
//   rx_data, rx_empty  FIFO head byte and empty flag
//   o_pop              one-cycle FIFO pop
//   o_mode             current mode
//   o_btn_tick         button ticks, slice [m*BTN_W +: BTN_W] belongs to mode m
//   o_event_time       one-cycle "t" pulse
//   o_err              one-cycle protocol / switch error pulse
module uart_cmd_router #(
   parameter int NUM_MODES   = 4,
   parameter int MODE_W      = $clog2(NUM_MODES),
   parameter int BTN_W       = 4,
   parameter int DB_DIV      = 100,
   parameter int DB_DEPTH    = 8,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [MODE_W-1:0]            sw,
   input  logic [BTN_W-1:0]             btn,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_empty,
   output logic                         o_pop,
   output logic [MODE_W-1:0]            o_mode,
   output logic [NUM_MODES*BTN_W-1:0]   o_btn_tick,
   output logic                         o_event_time,
   output logic                         o_err
);

   localparam int DIV_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
   localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, ARG, AEXEC} state_t;
   state_t state, state_nx;

   logic [7:0]        cmd_reg, arg_reg, digit;
   logic [TO_W-1:0]   timeout_cnt;
   logic              timeout_hit;
   logic [MODE_W-1:0] mode_reg, mode_nx;
   logic [BTN_W-1:0]  uart_btn, ubtn_nx;
   logic              pop_nx, evt_nx, err_nx, mode_ld;

   logic [MODE_W-1:0] sw_q1, sw_q2;
   logic              sw_edge, sw_ok;

   logic [DIV_W-1:0]    div_cnt;
   logic                samp_tick;
   logic [DB_DEPTH-1:0] db_sh [BTN_W];
   logic [BTN_W-1:0]    deb, deb_d, src;

   assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign digit       = arg_reg - 8'h30;
   assign sw_edge     = |(sw_q1 ^ sw_q2);
   // widened by one bit so NUM_MODES itself is representable in the compare
   assign sw_ok       = ({1'b0, sw_q1} < (MODE_W + 1)'(NUM_MODES));
   assign o_mode      = mode_reg;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!rx_empty) state_nx = EXEC;
         EXEC:    state_nx = (cmd_reg == "M" || cmd_reg == "b") ? ARG : IDLE;
         ARG:     if (!rx_empty) state_nx = AEXEC;
                  else if (timeout_hit) state_nx = IDLE;
         AEXEC:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // output logic: next values of the registered decode pulses
   always_comb begin
      pop_nx  = 1'b0;
      evt_nx  = 1'b0;
      err_nx  = 1'b0;
      mode_ld = 1'b0;
      mode_nx = mode_reg;
      ubtn_nx = '0;
      case (state)
         IDLE: pop_nx = !rx_empty;
         EXEC: begin
            if (cmd_reg == "m") begin
               mode_ld = 1'b1;
               mode_nx = (mode_reg == MODE_W'(NUM_MODES - 1)) ? '0 : mode_reg + 1'b1;
            end else if (cmd_reg == "t") begin
               evt_nx = 1'b1;
            end else if (cmd_reg != "M" && cmd_reg != "b") begin
               err_nx = 1'b1;
            end
         end
         ARG: begin
            if (!rx_empty)        pop_nx = 1'b1;
            else if (timeout_hit) err_nx = 1'b1;
         end
         AEXEC: begin
            if (arg_reg < "0" || arg_reg > "9") begin
               err_nx = 1'b1;
            end else if (cmd_reg == "M") begin
               if (digit < 8'(NUM_MODES)) begin
                  mode_ld = 1'b1;
                  mode_nx = digit[MODE_W-1:0];
               end else begin
                  err_nx = 1'b1;
               end
            end else if (digit < 8'(BTN_W)) begin
               for (int i = 0; i < BTN_W; i++)
                  if (digit == 8'(i)) ubtn_nx[i] = 1'b1;
            end else begin
               err_nx = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // command datapath, pulse registers and mode register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_reg      <= '0;
         arg_reg      <= '0;
         timeout_cnt  <= '0;
         o_pop        <= 1'b0;
         o_event_time <= 1'b0;
         o_err        <= 1'b0;
         uart_btn     <= '0;
         mode_reg     <= '0;
         sw_q1        <= '0;
         sw_q2        <= '0;
      end else begin
         if (state == IDLE && !rx_empty) cmd_reg <= rx_data;
         if (state == ARG && !rx_empty)  arg_reg <= rx_data;
         if (state == EXEC)
            timeout_cnt <= '0;
         else if (state == ARG && rx_empty && !timeout_hit)
            timeout_cnt <= timeout_cnt + 1'b1;
         o_pop        <= pop_nx;
         o_event_time <= evt_nx;
         uart_btn     <= ubtn_nx;
         sw_q1        <= sw;
         sw_q2        <= sw_q1;
         // a UART mode write in the same cycle swallows the switch edge entirely
         o_err        <= err_nx | (sw_edge && !sw_ok && !mode_ld);
         if (mode_ld)
            mode_reg <= mode_nx;
         else if (sw_edge && sw_ok)
            mode_reg <= sw_q1;
      end
   end

   // debounce: shared prescaler, per-button sample shift register
   assign samp_tick = (div_cnt == DIV_W'(DB_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         deb_d   <= '0;
         for (int i = 0; i < BTN_W; i++) db_sh[i] <= '0;
      end else begin
         div_cnt <= samp_tick ? '0 : div_cnt + 1'b1;
         deb_d   <= deb;
         if (samp_tick)
            for (int i = 0; i < BTN_W; i++)
               db_sh[i] <= {db_sh[i][DB_DEPTH-2:0], btn[i]};
      end
   end

   always_comb begin
      deb = '0;
      for (int i = 0; i < BTN_W; i++) deb[i] = &db_sh[i];
   end

   assign src = (deb & ~deb_d) | uart_btn;

   // router: uses mode_reg before any same-cycle update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_btn_tick <= '0;
      end else begin
         for (int m = 0; m < NUM_MODES; m++)
            o_btn_tick[m*BTN_W +: BTN_W] <= (mode_reg == MODE_W'(m)) ? src : '0;
      end
   end

endmodule

// File: tb/tb_uart_cmd_router.sv
// tb/tb_uart_cmd_router.sv - directed self-checking bench for uart_cmd_router
module tb_uart_cmd_router;

   localparam int NUM_MODES   = 4;
   localparam int MODE_W      = 2;
   localparam int BTN_W       = 4;
   localparam int DB_DIV      = 4;
   localparam int DB_DEPTH    = 8;
   localparam int TIMEOUT_CYC = 50;
   localparam int NB          = NUM_MODES * BTN_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [MODE_W-1:0] sw;
   logic [BTN_W-1:0]  btn;
   logic [7:0]        rx_data;
   logic              rx_empty;
   logic              o_pop;
   logic [MODE_W-1:0] o_mode;
   logic [NB-1:0]     o_btn_tick;
   logic              o_event_time;
   logic              o_err;

   always #5 clk = ~clk;

   uart_cmd_router #(
      .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .BTN_W(BTN_W),
      .DB_DIV(DB_DIV), .DB_DEPTH(DB_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .sw(sw), .btn(btn),
      .rx_data(rx_data), .rx_empty(rx_empty), .o_pop(o_pop),
      .o_mode(o_mode), .o_btn_tick(o_btn_tick),
      .o_event_time(o_event_time), .o_err(o_err)
   );

   logic [7:0] fifo [$];
   logic       pop_pend;
   int         pop_at [$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         pop_cnt, err_cnt, evt_cnt, cyc, first_err, gap;
   int         tick_hits [NB];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic refresh();
      rx_empty = (fifo.size() == 0);
      rx_data  = rx_empty ? 8'h00 : fifo[0];
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      refresh();
   endtask

   task automatic clear();
      pop_cnt = 0;
      err_cnt = 0;
      evt_cnt = 0;
      pop_at.delete();
      for (int i = 0; i < NB; i++) tick_hits[i] = 0;
   endtask

   // FIFO head advances after the edge that ends a cycle with o_pop high
   task automatic step();
      @(negedge clk);
      cyc++;
      if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
      pop_pend = o_pop && !rst;
      refresh();
      if (o_pop) begin
         pop_cnt++;
         pop_at.push_back(cyc);
      end
      if (o_err)        err_cnt++;
      if (o_event_time) evt_cnt++;
      for (int i = 0; i < NB; i++) if (o_btn_tick[i]) tick_hits[i]++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic int others(input int keep);
      int s = 0;
      for (int i = 0; i < NB; i++) if (i != keep) s += tick_hits[i];
      return s;
   endfunction

   initial begin
      rst = 1'b1; sw = '0; btn = '0; pop_pend = 1'b0; cyc = 0;
      clear();
      refresh();
      run(3);
      check("rst_mode", int'(o_mode), 0);
      check("rst_pop",  int'(o_pop), 0);
      check("rst_err",  int'(o_err), 0);
      check("rst_evt",  int'(o_event_time), 0);
      check("rst_tick", int'(o_btn_tick), 0);
      rst = 1'b0;
      run(2);

      // "m" steps the mode and wraps 3 -> 0
      for (int i = 0; i < 4; i++) begin
         clear(); push("m"); run(4);
         check("m_pops", pop_cnt, 1);
         check("m_mode", int'(o_mode), (i + 1) % 4);
      end

      clear(); push("t"); run(4);
      check("t_evt", evt_cnt, 1);
      check("t_err", err_cnt, 0);

      // "M2": pops at the EXEC and AEXEC cycles, two cycles apart
      clear(); push("M"); push("2"); run(6);
      gap = (pop_at.size() >= 2) ? pop_at[1] - pop_at[0] : -1;
      check("M2_pops", pop_cnt, 2);
      check("M2_gap",  gap, 2);
      check("M2_err",  err_cnt, 0);
      check("M2_mode", int'(o_mode), 2);

      clear(); push("M"); push("7"); run(6);
      check("M7_err",  err_cnt, 1);
      check("M7_mode", int'(o_mode), 2);

      clear(); push("M"); push("1"); run(6);
      check("M1_mode", int'(o_mode), 1);

      // mode 1, button 3 -> bit 1*4+3 = 7
      clear(); push("b"); push("3"); run(8);
      check("b3_bit7",   tick_hits[7], 1);
      check("b3_others", others(7), 0);
      check("b3_err",    err_cnt, 0);

      clear(); push("b"); push("9"); run(8);
      check("b9_err",  err_cnt, 1);
      check("b9_tick", others(-1), 0);

      // lone "M": EXEC entry, ARG entry, then TIMEOUT_CYC empty ARG cycles
      clear(); push("M"); first_err = -1;
      for (int k = 1; k <= 70; k++) begin
         step();
         if (o_err && first_err < 0) first_err = k;
      end
      check("to_at",   first_err, 2 + TIMEOUT_CYC);
      check("to_errs", err_cnt, 1);
      check("to_pops", pop_cnt, 1);

      clear(); push("1"); run(6);
      check("late_err",  err_cnt, 1);
      check("late_mode", int'(o_mode), 1);
      check("late_pops", pop_cnt, 1);

      // debounce in mode 3: btn[0] -> bit 12
      clear(); push("M"); push("3"); run(6);
      check("M3_mode", int'(o_mode), 3);
      clear();
      for (int p = 0; p < 5; p++) begin
         btn[0] = (p % 2 == 0);
         run(DB_DIV);
      end
      btn[0] = 1'b1; run(20 * DB_DIV);
      check("db_press1",  tick_hits[12], 1);
      check("db_others1", others(12), 0);
      btn[0] = 1'b0; run(12 * DB_DIV);
      check("db_release", tick_hits[12], 1);
      btn[0] = 1'b1; run(20 * DB_DIV);
      check("db_press2",  tick_hits[12], 2);
      check("db_others2", others(12), 0);
      btn[0] = 1'b0; run(12 * DB_DIV);

      // switch edge in the same cycle as the "m" decode: UART wins
      clear(); push("M"); push("0"); run(6);
      check("M0_mode", int'(o_mode), 0);
      clear(); push("m"); sw = 2'd2; run(4);
      check("race_mode", int'(o_mode), 1);
      check("race_err",  err_cnt, 0);
      sw = 2'd3; run(4);
      check("sw3_mode", int'(o_mode), 3);

      // reset while waiting for the argument byte
      clear(); push("M"); run(3);
      rst = 1'b1; sw = '0;
      run(2);
      check("mid_rst_mode", int'(o_mode), 0);
      check("mid_rst_pop",  int'(o_pop), 0);
      check("mid_rst_err",  int'(o_err), 0);
      check("mid_rst_evt",  int'(o_event_time), 0);
      check("mid_rst_tick", int'(o_btn_tick), 0);
      rst = 1'b0;
      clear(); run(10);
      check("post_rst_pops", pop_cnt, 0);
      check("post_rst_err",  err_cnt, 0);
      check("post_rst_mode", int'(o_mode), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
